// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 receive frame constants, frame FSM state type and odd-parity helper.
package ps2_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   DATA_BITS     = 8;
    localparam int   FIFO_BITS_DEF = 3;
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: show-ahead byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = FIFO_BITS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_din,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_full,
    output logic                 o_empty
);
    logic [FIFO_BITS:0]   r_wr_ptr, r_rd_ptr;
    logic [DATA_BITS-1:0] r_mem [2**FIFO_BITS];
    logic                 w_do_push, w_do_pop;
    assign o_empty   = r_wr_ptr == r_rd_ptr;
    assign o_full    = (r_wr_ptr[FIFO_BITS] != r_rd_ptr[FIFO_BITS]) &&
                       (r_wr_ptr[FIFO_BITS-1:0] == r_rd_ptr[FIFO_BITS-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[FIFO_BITS-1:0]];
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= i_din;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 device-to-host byte receiver with odd-parity check and receive FIFO.
// Optional frame timeout abort is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS      = FIFO_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk_sys,
    input  logic       i_reset_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_rx_parity_err,
    output logic       o_rx_frame_err,
    output logic       o_rx_overflow,
    output logic       o_busy
);
    ps2_state_t           r_state, w_state_nx;
    logic [1:0]           r_clk_sync, r_dat_sync;
    logic                 r_clk_prev;
    logic [2:0]           r_bit_cnt, w_cnt_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_parity, w_par_nx;
    logic                 r_pe, r_fe, r_ov;
    logic                 w_pe_nx, w_fe_nx, w_good;
    logic                 w_fall, w_dat, w_timeout, w_full, w_empty, w_pop;
    assign w_fall = r_clk_prev && !r_clk_sync[1];
    assign w_dat  = r_dat_sync[1];
    assign w_pop  = i_rx_ready && !w_empty;
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end
`ifdef PS2_RX_TIMEOUT_EN
    logic [16:0] r_to_cnt;
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) r_to_cnt <= '0;
        else if (w_fall) r_to_cnt <= '0;
        else if (r_state != ST_IDLE) r_to_cnt <= r_to_cnt + 17'd1;
    end
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == 17'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_par_nx   = r_parity;
        w_pe_nx    = 1'b0;
        w_fe_nx    = 1'b0;
        w_good     = 1'b0;
        if (w_timeout) begin
            w_state_nx = ST_IDLE;
            w_fe_nx    = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = (w_dat == START_BIT) ? ST_DATA : ST_IDLE;
                    w_cnt_nx   = '0;
                end
                ST_DATA: begin
                    w_shift_nx = {w_dat, r_shift[DATA_BITS-1:1]};
                    w_cnt_nx   = r_bit_cnt + 3'd1;
                    w_state_nx = (r_bit_cnt == 3'(DATA_BITS-1)) ? ST_PARITY : ST_DATA;
                end
                ST_PARITY: begin
                    w_par_nx   = w_dat;
                    w_state_nx = ST_STOP;
                end
                default: begin
                    // stop failure masks any parity failure
                    w_state_nx = ST_IDLE;
                    w_fe_nx    = w_dat != STOP_BIT;
                    w_pe_nx    = (w_dat == STOP_BIT) && !odd_parity_ok(r_shift, r_parity);
                    w_good     = (w_dat == STOP_BIT) && odd_parity_ok(r_shift, r_parity);
                end
            endcase
        end
    end
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_parity  <= w_par_nx;
            r_pe      <= w_pe_nx;
            r_fe      <= w_fe_nx;
            r_ov      <= w_good && w_full && !w_pop;
        end
    end
    ps2_rx_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
        .i_clk   (i_clk_sys),
        .i_rst_n (i_reset_n),
        .i_push  (w_good),
        .i_din   (w_shift_nx),
        .i_pop   (w_pop),
        .o_dout  (o_rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign o_rx_valid      = !w_empty;
    assign o_rx_parity_err = r_pe;
    assign o_rx_frame_err  = r_fe;
    assign o_rx_overflow   = r_ov;
    assign o_busy          = r_state != ST_IDLE;
endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: directed bench for ps2_host_rx; timeout steps depend on PS2_RX_TIMEOUT_EN.
module tb_ps2_host_rx;
    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, pe, fe, ov, busy;
    int         n_chk = 0, n_pass = 0, n_fail = 0, n_pe = 0, n_fe = 0, n_ov = 0;

    always #5 clk = ~clk;

    ps2_host_rx #(.FIFO_BITS(3), .TIMEOUT_CYCLES(1000)) dut (
        .i_clk_sys       (clk),
        .i_reset_n       (rst_n),
        .i_ps2_clk       (ps2_clk),
        .i_ps2_data      (ps2_data),
        .o_rx_data       (rx_data),
        .o_rx_valid      (rx_valid),
        .i_rx_ready      (rx_ready),
        .o_rx_parity_err (pe),
        .o_rx_frame_err  (fe),
        .o_rx_overflow   (ov),
        .o_busy          (busy)
    );

    always @(negedge clk) begin
        if (pe) n_pe++;
        if (fe) n_fe++;
        if (ov) n_ov++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(20);
        ps2_clk = 1'b1;
        cyc(10);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_good(input logic [7:0] d);
        send_bits(frame(d, ~^d, 1'b1), 11);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        cyc(3);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {29'd0, pe, fe, ov}, 32'd0);
        rst_n = 1'b1;
        cyc(2);
        // falling edge with data high while idle is ignored
        ps2_bit(1'b1);
        check("idle_one_busy", {31'd0, busy}, 32'd0);
        check("idle_one_fe", n_fe, 0);
        // good frame 0x1C with exact push latency
        send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
        ps2_data = 1'b1;
        cyc(10);
        check("good_busy", {31'd0, busy}, 32'd1);
        ps2_clk = 1'b0;
        cyc(2);
        check("good_valid_early", {31'd0, rx_valid}, 32'd0);
        cyc(1);
        check("good_valid", {31'd0, rx_valid}, 32'd1);
        check("good_data", {24'd0, rx_data}, 32'h1C);
        check("good_busy_done", {31'd0, busy}, 32'd0);
        ps2_clk = 1'b1;
        cyc(10);
        check("good_no_err", n_pe + n_fe + n_ov, 0);
        // reset mid-frame drops the partial frame and the FIFO
        send_bits(frame(8'h55, 1'b1, 1'b1), 4);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        cyc(2);
        send_good(8'h3A);
        pop_check("after_rst", 8'h3A);
        check("after_rst_empty", {31'd0, rx_valid}, 32'd0);
        // parity failure
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11);
        check("par_pe", n_pe, 1);
        check("par_fe", n_fe, 0);
        check("par_valid", {31'd0, rx_valid}, 32'd0);
        // stop failure, then stop failure masking a parity failure
        send_bits(frame(8'h00, 1'b1, 1'b0), 11);
        check("stop_fe", n_fe, 1);
        check("stop_valid", {31'd0, rx_valid}, 32'd0);
        send_bits(frame(8'h00, 1'b0, 1'b0), 11);
        check("both_fe", n_fe, 2);
        check("both_pe", n_pe, 1);
        // overflow on the ninth byte
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        check("ovf_before", n_ov, 0);
        send_good(8'h09);
        check("ovf_pulse", n_ov, 1);
        for (int i = 1; i <= 8; i++) pop_check("ovf_pop", 8'(i));
        check("ovf_empty", {31'd0, rx_valid}, 32'd0);
        // ninth push coincides with a pop on a full FIFO
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        send_bits(frame(8'h09, 1'b1, 1'b1), 10);
        ps2_data = 1'b1;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(2);
        check("pp_head", {24'd0, rx_data}, 32'h01);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        ps2_clk = 1'b1;
        cyc(10);
        check("pp_no_ovf", n_ov, 1);
        for (int i = 2; i <= 9; i++) pop_check("pp_pop", 8'(i));
        check("pp_empty", {31'd0, rx_valid}, 32'd0);
        // clock stalls after four data bits
        send_bits(frame(8'h0F, 1'b1, 1'b1), 5);
        check("stall_busy", {31'd0, busy}, 32'd1);
        cyc(850);
        check("stall_busy_mid", {31'd0, busy}, 32'd1);
        check("stall_fe_mid", n_fe, 2);
        cyc(200);
`ifdef PS2_RX_TIMEOUT_EN
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_fe", n_fe, 3);
`else
        check("noto_busy", {31'd0, busy}, 32'd1);
        check("noto_fe", n_fe, 2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
`endif
        send_good(8'hAA);
        pop_check("after_stall", 8'hAA);
        check("after_stall_pe", n_pe, 1);
        check("after_stall_valid", {31'd0, rx_valid}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_host_rx.md
PS2_HOST_RX -- requirements
Module: ps2_host_rx

Interface
REQ-001 SHALL have parameter FIFO_BITS, default 3, log2 of the receive FIFO depth (8 entries).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, the number of clk_sys cycles without a PS/2 clock falling edge that aborts a frame in progress.
REQ-003 clk_sys  in  1  system clock; all logic on posedge; nominally 24-100 MHz.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ps2_clk  in  1  PS/2 clock from the device; asynchronous; 10-16 kHz; held high when idle.
REQ-006 ps2_data  in  1  PS/2 data from the device; asynchronous.
REQ-007 rx_data  out  8  byte at the FIFO head (show-ahead).
REQ-008 rx_valid  out  1  FIFO not empty.
REQ-009 rx_ready  in  1  consumer pop; a byte is popped in any cycle where rx_valid and rx_ready are both 1.
REQ-010 rx_parity_err  out  1  one-cycle pulse on a frame discarded for parity failure.
REQ-011 rx_frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout abort.
REQ-012 rx_overflow  out  1  one-cycle pulse on a good byte dropped because the FIFO is full.
REQ-013 busy  out  1  high while the frame FSM is outside IDLE.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected from the synchronized clock and its previous value, so edge detection occurs 3 cycles after the pin edge.
REQ-015 Data SHALL be sampled only on a detected falling edge, using the synchronized ps2_data value of that cycle.
REQ-016 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-017 In IDLE, a falling edge with data 0 SHALL start a frame (go to DATA, bit count 0); a falling edge with data 1 SHALL be ignored with no error.
REQ-018 In DATA, the 8 data bits SHALL be shifted in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-019 In PARITY, the parity bit SHALL be captured, then the FSM SHALL go to STOP.
REQ-020 Parity is odd: parity is OK when the count of ones across the 8 data bits plus the parity bit is odd.
REQ-021 In STOP, the stop-bit edge SHALL resolve the frame and return the FSM to IDLE, as follows.
- stop=0: rx_frame_err pulse; byte discarded. A stop failure takes precedence over a parity failure.
- stop=1 with parity bad: rx_parity_err pulse; byte discarded.
- stop=1 with parity OK and FIFO not full: byte pushed.
- stop=1 with parity OK and FIFO full: rx_overflow pulse; byte dropped; FIFO contents unchanged.
REQ-022 A pushed byte SHALL appear on rx_data with rx_valid=1 in the cycle after the stop-bit edge detection.
REQ-023 A push into a full FIFO SHALL be accepted, with no overflow, when a pop happens in the same cycle.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL NOT occur, because rx_valid=0; the push alone is performed.
REQ-025 FIFO pointers are FIFO_BITS+1 wide with natural wrap-around; full means the MSBs differ and the low bits are equal.
REQ-026 rx_data is don't-care while rx_valid=0.

Reset
REQ-027 On reset_n low, asynchronously: FSM to IDLE; bit count, shift register and pointers to 0; rx_valid, busy and all error pulses to 0; synchronizer flops to 1 (idle-high).
REQ-028 Reset during a frame SHALL discard the partial frame and empty the FIFO; after release, the next falling edge with data 0 starts a new frame.

Configuration
REQ-029 With PS2_RX_TIMEOUT_EN defined, a 17-bit counter SHALL clear on every detected falling edge and increment while the FSM is not in IDLE.
REQ-030 With PS2_RX_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL force IDLE, pulse rx_frame_err and discard the partial byte.
REQ-031 Without PS2_RX_TIMEOUT_EN, the counter SHALL be absent and the FSM SHALL leave DATA, PARITY or STOP only through clock edges or reset.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state enum, the frame constants (START=0, STOP=1, 8 data bits) and the default FIFO_BITS.
REQ-033 The FIFO SHALL be the sub-module ps2_rx_fifo: show-ahead, parameterized by FIFO_BITS, with push, pop, full and empty.

Verification
REQ-034 The bench SHALL cover a good frame: frame 0x1C with parity 0 and stop 1 -> rx_valid=1 and rx_data=0x1C one cycle after stop-edge detection; no error pulses.
REQ-035 The bench SHALL cover a bad parity bit: frame 0xF0 with parity 0 -> a single rx_parity_err pulse; rx_valid stays 0.
REQ-036 The bench SHALL cover a bad stop bit: frame 0x00 with parity 1 and stop 0 -> a single rx_frame_err pulse; no push.
REQ-037 The bench SHALL cover overflow: 9 good frames 0x01..0x09 with rx_ready=0 -> rx_overflow pulse on the 9th; pops return 0x01..0x08.
REQ-038 The bench SHALL cover a same-cycle push and pop on a full FIFO: the 9th stop edge coincides with a pop -> no overflow; pops return 0x02..0x09.
REQ-039 The bench SHALL cover timeout with PS2_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=1000: ps2_clk stops after 4 data bits -> rx_frame_err pulse; busy=0 after 1000 cycles; the next full 0xAA frame is received correctly.
